register_file_32: RTL and testbench
===================================

// Module: register_file_32
//
// PURPOSE
//  32-entry general-purpose register file for the CPU datapath: two read
//  ports, one write port. Sits directly upstream of the 32-input read-select
//  multiplexers. Each read port selects one of the 32 register outputs by
//  5-bit address.
//  Feeds ALU operand A/B selection. Write data comes from the writeback stage.
//
// PARAMETERS
//  width  32  data width of each register and of every data port (bits)
//
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high; clears all registers
//  write_enable  in   1      1 = write write_data to write_addr at next edge
//  write_addr    in   5      destination register index
//  write_data    in   width  data to store
//  read_addr1    in   5      read port 1 register index
//  read_addr2    in   5      read port 2 register index
//  read_data1    out  width  contents of register read_addr1
//  read_data2    out  width  contents of register read_addr2
//
// BEHAVIOUR
//  - Storage: 32 registers r0..r31, each width bits, all clocked by clk.
//  - Reset: rising edge with reset=1 sets r0..r31 to 0. Reset beats a
//    concurrent write; that write is dropped.
//  - Reset outputs: after a reset edge, read_data1 and read_data2 are 0 for
//    every address until a write occurs.
//  - Write: rising edge with reset=0, write_enable=1 and write_addr!=0 sets
//    r[write_addr] <= write_data. All other registers hold.
//  - r0: hardwired to zero. Writes to address 0 are ignored. Reading address
//    0 returns 0 on both ports at all times.
//  - Write decode: 5-to-32 one-hot decoder gated by write_enable. The
//    decoder output is forced to 0 when write_addr=0 or when reset=1.
//  - Read: combinational (0-cycle latency). Each port is a 32:1 width-bit
//    mux over r0..r31, addressed by its read_addr.
//  - Both ports are independent. Equal addresses on both ports return
//    identical data.
//  - Read-during-write to the same address, same cycle: returns the OLD
//    value. The new value appears after the rising edge (macro disabled).
//  - write_enable=0: write_addr and write_data are don't-care; no state
//    changes.
//  - Reset asserted mid-sequence: a write in progress on that edge is lost.
//    The first write after reset deasserts completes normally.
//
// CONFIGURATION
//  REGFILE_BYPASS_EN
//   Defined: write-through forwarding. If write_enable=1, reset=0,
//   write_addr!=0 and read_addrN==write_addr, then read_dataN=write_data
//   combinationally in the same cycle. The register still updates at the
//   edge. Applies to each port independently. Address 0 never forwards.
//   Undefined: no forwarding; read-during-write returns the old value.
//
// TESTING
//  1 Reset: load nonzero values into all regs, assert reset for 1 edge,
//    sweep read_addr1/2 over 0..31 -> all reads 0.
//  2 Write/read: write r5=32'hDEADBEEF and r31=32'h12345678 ->
//    read_addr1=5 gives DEADBEEF; read_addr2=31 gives 12345678.
//  3 r0 protect: write r0=32'hFFFFFFFF -> read of address 0 on both ports
//    stays 0.
//  4 Enable gating: write_enable=0, write_addr=7, write_data=32'hA5A5A5A5
//    for 3 edges -> r7 is unchanged.
//  5 Read-during-write: r9=32'h1, write r9=32'h2, read_addr1=9 before the
//    edge -> 1 without macro, 2 with REGFILE_BYPASS_EN. Both builds read 2
//    after the edge.
//  6 Reset vs write: reset=1 and write r3=32'h55 on the same edge ->
//    r3 reads 0 afterwards. A full 32-register write/readback sweep on both
//    ports matches a reference model.

Source files
------------

// File: rtl/register_file_32.sv
// register_file_32: 32 x width general-purpose register file, two
// combinational read ports and one synchronous write port.
// r0 reads as zero at all times and ignores writes.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write on
// the current cycle is forwarded straight to any read port whose address
// matches. When it is undefined, a same-cycle read returns the stored value.
module register_file_32 #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [4:0]       write_addr,
  input  logic [width-1:0] write_data,
  input  logic [4:0]       read_addr1,
  input  logic [4:0]       read_addr2,
  output logic [width-1:0] read_data1,
  output logic [width-1:0] read_data2
);

  logic [width-1:0] regs [32];
  logic [31:0]      wr_dec;

  // Select one register from the array; address 0 is forced to zero.
  function automatic logic [width-1:0] read_mux(input logic [4:0] addr,
                                                input logic [width-1:0] cur);
    read_mux = (addr == 5'd0) ? '0 : cur;
  endfunction

  // One-hot write decode; it is suppressed during reset and for address 0.
  always_comb begin
    wr_dec = '0;
    if (write_enable && !reset && (write_addr != 5'd0))
      wr_dec[write_addr] = 1'b1;
  end

  // Register storage. Reset clears every entry and takes priority over a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset)
        regs[i] <= '0;
      else if (wr_dec[i])
        regs[i] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read muxes with write-through forwarding. wr_dec is never set for
  // address 0, so r0 is never forwarded.
  always_comb begin
    read_data1 = read_mux(read_addr1, regs[read_addr1]);
    read_data2 = read_mux(read_addr2, regs[read_addr2]);
    if (wr_dec[read_addr1]) read_data1 = write_data;
    if (wr_dec[read_addr2]) read_data2 = write_data;
  end
`else
  // Plain read muxes. A same-cycle write becomes visible only after the edge.
  always_comb begin
    read_data1 = read_mux(read_addr1, regs[read_addr1]);
    read_data2 = read_mux(read_addr2, regs[read_addr2]);
  end
`endif

endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32: randomized and directed test of register_file_32,
// checked against an array-based reference model.
module tb_register_file_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [32];

  register_file_32 #(.width(32)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value for the inputs currently being driven.
  function automatic logic [31:0] expect_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (write_enable && !reset && write_addr != 5'd0 && addr == write_addr)
      return write_data;
`endif
    return model[addr];
  endfunction

  // Drive one cycle, optionally check both ports before the edge, then
  // advance the model across the edge.
  task automatic do_cycle(input bit chk, input logic rst, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] ra1, input logic [4:0] ra2,
                          input string tag);
    reset = rst; write_enable = we; write_addr = wa; write_data = wd;
    read_addr1 = ra1; read_addr2 = ra2;
    #2;
    if (chk) begin
      check($sformatf("%s rd1[%0d]", tag, ra1), read_data1, expect_read(ra1));
      check($sformatf("%s rd2[%0d]", tag, ra2), read_data2, expect_read(ra2));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    do_cycle(0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "init");
    for (int i = 0; i < 32; i++)
      do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "rst0");

    // Load nonzero data everywhere, pulse reset, sweep reads.
    for (int i = 1; i < 32; i++)
      do_cycle(0, 1'b0, 1'b1, 5'(i), $urandom | 32'h1, 5'd0, 5'd0, "load");
    do_cycle(1, 1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "rstpulse");
    for (int i = 0; i < 32; i++) begin
      do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "rstsweep");
      check("rstconst", read_data1, 32'h0);
    end

    // Directed write and readback.
    do_cycle(1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31, "wr5");
    do_cycle(1, 1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, "wr31");
    do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "rd");
    reset = 1'b0; write_enable = 1'b0; read_addr1 = 5'd5; read_addr2 = 5'd31; #1;
    check("r5const", read_data1, 32'hDEADBEEF);
    check("r31const", read_data2, 32'h12345678);

    // r0 ignores writes, including with bypass builds.
    do_cycle(1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "r0wr");
    do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "r0rd");

    // write_enable=0 leaves r7 untouched.
    do_cycle(0, 1'b0, 1'b1, 5'd7, 32'h0000_0777, 5'd0, 5'd0, "r7set");
    for (int k = 0; k < 3; k++)
      do_cycle(1, 1'b0, 1'b0, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, "gate");
    do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "gate_after");

    // Read during write to the same register.
    do_cycle(0, 1'b0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, "r9set");
    write_enable = 1'b1; write_addr = 5'd9; write_data = 32'h2; read_addr1 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before", read_data1, 32'h2);
`else
    check("rdw_before", read_data1, 32'h1);
`endif
    do_cycle(1, 1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, "rdw");
    do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "rdw_after");
    check("rdw_after_const", read_data1, 32'h2);

    // Reset beats a concurrent write; the next write completes normally.
    do_cycle(0, 1'b0, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, "r3set");
    do_cycle(1, 1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, "rstwr");
    do_cycle(1, 1'b0, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4, "postrst");
    do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, "postrst_rd");
    check("r3const", read_data1, 32'h0);
    check("r4const", read_data2, 32'h44);

    // Full write sweep then readback on both ports.
    for (int i = 0; i < 32; i++)
      do_cycle(1, 1'b0, 1'b1, 5'(i), $urandom, 5'(i), 5'($urandom_range(0, 31)), "sweepwr");
    for (int i = 0; i < 32; i++)
      do_cycle(1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "sweeprd");

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      do_cycle(1, ($urandom_range(0, 49) == 0), 1'($urandom), wa, $urandom,
               ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
